// File: rtl/handshake_fifo_pkg.sv
// Shared constants and helpers for the pull-style req/ack elastic buffer.
// Imported by the interface, the storage array and the top level.
package handshake_fifo_pkg;

  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultDepth     = 4;

  // Levels of the req/ack handshake wires.
  localparam logic ReqIdle   = 1'b0;
  localparam logic ReqActive = 1'b1;
  localparam logic AckIdle   = 1'b0;
  localparam logic AckPulse  = 1'b1;

  // Smallest n with 2**n >= value; used to size the pointers.
  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/handshake_fifo_if.sv
// Bundle of the upstream/downstream handshake wires plus status of one FIFO arc.
// The master modport is the FIFO itself; slave is whatever surrounds it.
interface handshake_fifo_if #(
  parameter int unsigned DataWidth = handshake_fifo_pkg::DefaultDataWidth,
  parameter int unsigned Depth     = handshake_fifo_pkg::DefaultDepth,
  localparam int unsigned AddrWidth = handshake_fifo_pkg::log2_ceil(Depth)
);

  logic                 req_l;
  logic                 ack_l;
  logic [DataWidth-1:0] din;
  logic                 req_r;
  logic                 ack_r;
  logic [DataWidth-1:0] dout;
  logic [AddrWidth:0]   count;
  logic                 overflow;

  modport master (
    output req_l,
    input  ack_l,
    input  din,
    input  req_r,
    output ack_r,
    output dout,
    output count,
    output overflow
  );

  modport slave (
    input  req_l,
    output ack_l,
    output din,
    output req_r,
    input  ack_r,
    input  dout,
    input  count,
    input  overflow
  );

endinterface

// File: rtl/handshake_fifo_ram.sv
// Depth x DataWidth storage: synchronous write, combinational read.
// Contents are not reset; the pointers in the top level define what is valid.
module handshake_fifo_ram
  import handshake_fifo_pkg::*;
#(
  parameter int unsigned DataWidth = DefaultDataWidth,
  parameter int unsigned Depth     = DefaultDepth,
  localparam int unsigned AddrWidth = log2_ceil(Depth)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/handshake_fifo.sv
// Elastic buffer on one dataflow arc: requester upstream, provider downstream,
// both using the one-outstanding-request req/ack pull protocol.
module handshake_fifo
  import handshake_fifo_pkg::*;
#(
  parameter int unsigned DataWidth = DefaultDataWidth,
  parameter int unsigned Depth     = DefaultDepth
) (
  input  logic             clk,
  input  logic             rst,
  handshake_fifo_if.master bus_io
);

  localparam int unsigned AddrWidth = log2_ceil(Depth);
  localparam logic [AddrWidth:0] DepthCount = (AddrWidth + 1)'(Depth);

  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrWidth:0]   count_q, count_d;
  logic                 req_l_q, req_l_d;
  logic                 ack_r_q, ack_r_d;
  logic                 overflow_q, overflow_d;
  logic [DataWidth-1:0] dout_q, dout_d;
  logic [DataWidth-1:0] ram_rdata;
  logic                 full, empty, push, pop;

  handshake_fifo_ram #(
    .DataWidth (DataWidth),
    .Depth     (Depth)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus_io.din),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    full  = (count_q == DepthCount);
    empty = (count_q == '0);
    // An ack while full is a producer error: the word is dropped, not stored.
    push  = bus_io.ack_l & ~full;
    // ack_r is a one-cycle pulse, so a pop is never granted two edges running.
    pop   = bus_io.req_r & ~ack_r_q & ~empty;

    wr_ptr_d = push ? wr_ptr_q + AddrWidth'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AddrWidth'(1) : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + (AddrWidth + 1)'(1);
      2'b01:   count_d = count_q - (AddrWidth + 1)'(1);
      default: count_d = count_q;
    endcase

    if (bus_io.ack_l == AckPulse) begin
      req_l_d = ReqIdle;
    end else if ((req_l_q == ReqIdle) && (count_d < DepthCount)) begin
      req_l_d = ReqActive;
    end else begin
      req_l_d = req_l_q;
    end

    ack_r_d    = pop ? AckPulse : AckIdle;
    dout_d     = pop ? ram_rdata : dout_q;
    overflow_d = overflow_q | (bus_io.ack_l & full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      req_l_q    <= ReqIdle;
      ack_r_q    <= AckIdle;
      overflow_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      req_l_q    <= req_l_d;
      ack_r_q    <= ack_r_d;
      overflow_q <= overflow_d;
      dout_q     <= dout_d;
    end
  end

  assign bus_io.req_l    = req_l_q;
  assign bus_io.ack_r    = ack_r_q;
  assign bus_io.dout     = dout_q;
  assign bus_io.count    = count_q;
  assign bus_io.overflow = overflow_q;

  ack_r_single_cycle: assert property (@(posedge clk) disable iff (rst) ack_r_q |=> !ack_r_q);
  count_in_range:     assert property (@(posedge clk) disable iff (rst) count_q <= DepthCount);

endmodule

// File: tb/tb_handshake_fifo.sv
// Randomized bench for handshake_fifo against a queue-based model of the arc.
module tb_handshake_fifo;
  import handshake_fifo_pkg::*;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned Depth     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  handshake_fifo_if #(.DataWidth(DataWidth), .Depth(Depth)) bus ();

  handshake_fifo #(
    .DataWidth (DataWidth),
    .Depth     (Depth)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the FIFO contents as a queue plus the handshake outputs.
  logic [31:0] mq[$];
  bit          m_req;
  bit          m_ack;
  bit          m_ovf;
  logic [31:0] m_dout;

  function automatic void model_reset();
    mq.delete();
    m_req  = 1'b0;
    m_ack  = 1'b0;
    m_ovf  = 1'b0;
    m_dout = '0;
  endfunction

  function automatic void model_edge(input bit a, input logic [31:0] d, input bit r);
    bit was_full;
    bit do_pop;
    was_full = (mq.size() == Depth);
    do_pop   = r && !m_ack && (mq.size() > 0);
    if (do_pop) m_dout = mq.pop_front();
    m_ack = do_pop;
    if (a) begin
      if (!was_full) mq.push_back(d);
      else m_ovf = 1'b1;
      m_req = 1'b0;
    end else if (!m_req && (mq.size() < Depth)) begin
      m_req = 1'b1;
    end
  endfunction

  // Stimulus state
  bit          prod_en   = 1'b0;
  int unsigned prod_fail = 0;
  int unsigned prod_val  = 0;
  int unsigned prod_acks = 0;
  bit          cons_en   = 1'b0;
  int unsigned cons_fail = 0;
  bit          seq_chk   = 1'b0;
  int unsigned cons_next = 0;

  task automatic drive();
    if (prod_en) begin
      if (bus.req_l && !bus.ack_l && ($urandom_range(99) >= prod_fail)) begin
        bus.ack_l = 1'b1;
        bus.din   = prod_val;
        prod_val++;
        prod_acks++;
      end else begin
        bus.ack_l = 1'b0;
        bus.din   = $urandom;
      end
    end
    if (cons_en) bus.req_r = ($urandom_range(99) >= cons_fail);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(bus.ack_l, bus.din, bus.req_r);
    #1;
    check_eq("req_l", 32'(bus.req_l), 32'(m_req));
    check_eq("ack_r", 32'(bus.ack_r), 32'(m_ack));
    check_eq("count", 32'(bus.count), 32'(mq.size()));
    check_eq("overflow", 32'(bus.overflow), 32'(m_ovf));
    check_eq("dout", bus.dout, m_dout);
    if (seq_chk && bus.ack_r) begin
      check_eq("order", bus.dout, cons_next);
      cons_next++;
    end
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    bus.ack_l = 1'b0;
    bus.req_r = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic fill();
    prod_en   = 1'b1;
    prod_fail = 0;
    prod_val  = 0;
    prod_acks = 0;
    cons_en   = 1'b0;
    bus.req_r = 1'b0;
    repeat (20) begin
      drive();
      tick();
    end
    prod_en   = 1'b0;
    bus.ack_l = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ack_l = 1'b1;
    bus.din   = '0;
    bus.req_r = 1'b1;

    // Reset held with both handshakes active
    repeat (3) tick();
    rst       = 1'b0;
    bus.ack_l = 1'b0;
    bus.req_r = 1'b0;

    // Fill with no consumer
    fill();
    check_eq("fill_count", 32'(bus.count), 32'd4);
    check_eq("fill_acks", prod_acks, 32'd4);
    check_eq("fill_req_l", 32'(bus.req_l), 32'd0);

    // Drain with no producer
    seq_chk   = 1'b1;
    cons_next = 0;
    bus.req_r = 1'b1;
    repeat (12) tick();
    check_eq("drain_words", cons_next, 32'd4);
    check_eq("drain_count", 32'(bus.count), 32'd0);
    seq_chk = 1'b0;

    // Simultaneous push and pop at count 2
    reset_dut();
    bus.ack_l = 1'b1;
    bus.din   = 32'hA0;
    tick();
    bus.din = 32'hA1;
    tick();
    bus.din   = 32'hA2;
    bus.req_r = 1'b1;
    tick();
    check_eq("simul_count", 32'(bus.count), 32'd2);
    check_eq("simul_dout", bus.dout, 32'hA0);
    bus.ack_l = 1'b0;
    repeat (2) tick();
    check_eq("simul_next", bus.dout, 32'hA1);
    repeat (2) tick();
    check_eq("simul_last", bus.dout, 32'hA2);
    bus.req_r = 1'b0;

    // Full-rate stream, then a randomly stalled stream
    reset_dut();
    prod_en   = 1'b1;
    prod_fail = 0;
    prod_val  = 0;
    cons_en   = 1'b1;
    cons_fail = 0;
    seq_chk   = 1'b1;
    cons_next = 0;
    for (int c = 0; c < 30000 && cons_next < 5000; c++) begin
      drive();
      tick();
    end
    check_eq("stream_words", cons_next, 32'd5000);
    check_eq("stream_ovf", 32'(bus.overflow), 32'd0);
    prod_fail = 40;
    cons_fail = 50;
    for (int c = 0; c < 20000 && cons_next < 5600; c++) begin
      drive();
      tick();
    end
    check_eq("rand_words", cons_next, 32'd5600);

    // Producer acks while full
    prod_en = 1'b0;
    cons_en = 1'b0;
    seq_chk = 1'b0;
    reset_dut();
    fill();
    bus.ack_l = 1'b1;
    bus.din   = 32'hDEAD;
    repeat (2) tick();
    bus.ack_l = 1'b0;
    check_eq("ovf_set", 32'(bus.overflow), 32'd1);
    repeat (3) tick();
    check_eq("ovf_sticky", 32'(bus.overflow), 32'd1);
    seq_chk   = 1'b1;
    cons_next = 0;
    bus.req_r = 1'b1;
    repeat (12) tick();
    check_eq("ovf_drain", cons_next, 32'd4);
    check_eq("ovf_after_drain", 32'(bus.overflow), 32'd1);

    // Reset asserted between edges mid-stream
    prod_en   = 1'b1;
    prod_fail = 0;
    prod_val  = 0;
    cons_en   = 1'b1;
    cons_fail = 0;
    cons_next = 0;
    repeat (41) begin
      drive();
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_count", 32'(bus.count), 32'd0);
    check_eq("async_req_l", 32'(bus.req_l), 32'd0);
    check_eq("async_ack_r", 32'(bus.ack_r), 32'd0);
    check_eq("async_ovf", 32'(bus.overflow), 32'd0);
    check_eq("async_dout", bus.dout, 32'd0);
    prod_en   = 1'b0;
    cons_en   = 1'b0;
    seq_chk   = 1'b0;
    bus.ack_l = 1'b0;
    bus.req_r = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
